// File: rtl/out_fifo.sv
// rtl/out_fifo.sv - per-column first-word-fall-through output FIFO, popped one full row at a time
// Optional sticky overflow flag: define OUT_FIFO_OVERFLOW_FLAG_EN.
module out_fifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_err
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [psum_bw-1:0] mem_q  [col][depth];
    logic [AW:0]        wptr_q [col];
    logic [AW:0]        wptr_d [col];
    logic [AW:0]        rptr_q [col];
    logic [AW:0]        rptr_d [col];

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic [col-1:0] wr_en;
    logic           rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty = '0;
        full  = '0;
        for (int k = 0; k < col; k++) begin
            empty[k] = (wptr_q[k] == rptr_q[k]);
            full[k]  = (wptr_q[k][AW-1:0] == rptr_q[k][AW-1:0]) &&
                       (wptr_q[k][AW] != rptr_q[k][AW]);
        end
    end

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign wr_en   = wr & ~full;
    assign rd_en   = rd & o_valid;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        for (int k = 0; k < col; k++) begin
            if (wr_en[k]) begin
                wptr_d[k] = wptr_q[k] + PTR_ONE;
            end
            if (rd_en) begin
                rptr_d[k] = rptr_q[k] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < col; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset; a write landing during reset is orphaned by the pointer clear.
    always_ff @(posedge clk) begin
        for (int k = 0; k < col; k++) begin
            if (wr_en[k]) begin
                mem_q[k][wptr_q[k][AW-1:0]] <= in[k*psum_bw +: psum_bw];
            end
        end
    end

    always_comb begin
        out = '0;
        for (int k = 0; k < col; k++) begin
            out[k*psum_bw +: psum_bw] = mem_q[k][rptr_q[k][AW-1:0]];
        end
    end

`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (|(wr & full)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_out_fifo.sv
// tb/tb_out_fifo.sv - self-checking bench for out_fifo: vector table, directed corners, random vs queue model
module tb_out_fifo;

    localparam int COL   = 8;
    localparam int PB    = 16;
    localparam int DEPTH = 16;
`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [PB*COL-1:0] in;
    logic [COL-1:0]    wr;
    logic              rd;
    logic [PB*COL-1:0] out;
    logic              o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_err;

    out_fifo #(.col(COL), .psum_bw(PB), .depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PB-1:0] mq [COL][$];
    bit            err_m = 1'b0;

    typedef struct {
        bit            rst;
        logic [7:0]    wr;
        bit            rd;
        logic [PB-1:0] base;
        bit            exp_valid;
        bit            exp_full;
        logic [PB-1:0] exp_head;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PB*COL-1:0] row_inc(input logic [PB-1:0] base);
        logic [PB*COL-1:0] r;
        for (int k = 0; k < COL; k++) r[k*PB +: PB] = base + PB'(k);
        return r;
    endfunction

    function automatic logic [PB*COL-1:0] row_same(input logic [PB-1:0] v);
        logic [PB*COL-1:0] r;
        for (int k = 0; k < COL; k++) r[k*PB +: PB] = v;
        return r;
    endfunction

    function automatic logic [PB*COL-1:0] row_rand();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: one queue per lane; a row pops only when every queue holds data.
    task automatic model_edge();
        bit all_ne;
        if (reset) begin
            for (int k = 0; k < COL; k++) mq[k].delete();
            err_m = 1'b0;
        end else begin
            all_ne = 1'b1;
            for (int k = 0; k < COL; k++) if (mq[k].size() == 0) all_ne = 1'b0;
            for (int k = 0; k < COL; k++) begin
                if (wr[k]) begin
                    if (mq[k].size() < DEPTH) mq[k].push_back(in[k*PB +: PB]);
                    else if (ERR_EN) err_m = 1'b1;
                end
            end
            if (rd && all_ne) for (int k = 0; k < COL; k++) void'(mq[k].pop_front());
        end
    endtask

    task automatic cycle(input bit r, input logic [COL-1:0] w, input bit rr, input logic [PB*COL-1:0] d);
        reset = r;
        wr    = w;
        rd    = rr;
        in    = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        bit v_m;
        bit f_m;
        v_m = 1'b1;
        f_m = 1'b0;
        for (int k = 0; k < COL; k++) begin
            if (mq[k].size() == 0) v_m = 1'b0;
            if (mq[k].size() == DEPTH) f_m = 1'b1;
        end
        chk({tag, " o_valid"}, 32'(o_valid), 32'(v_m));
        chk({tag, " o_full"}, 32'(o_full), 32'(f_m));
        chk({tag, " o_ready"}, 32'(o_ready), 32'(!f_m));
        chk({tag, " o_err"}, 32'(o_err), 32'(err_m));
        if (v_m) begin
            for (int k = 0; k < COL; k++)
                chk($sformatf("%s out lane %0d", tag, k), 32'(out[k*PB +: PB]), 32'(mq[k][0]));
        end
    endtask

    task automatic chk_row(input string name, input logic [PB*COL-1:0] exp);
        for (int k = 0; k < COL; k++)
            chk($sformatf("%s lane %0d", name, k), 32'(out[k*PB +: PB]), 32'(exp[k*PB +: PB]));
    endtask

    logic [PB*COL-1:0] d;
    logic [COL-1:0]    w;
    int                rdp;

    initial begin
        // Reset, full-row write, pop; then lanes written one at a time, lane 7 first.
        vt[0]  = '{1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vt[1]  = '{1'b0, 8'hFF, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h0001};
        vt[2]  = '{1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
        for (int i = 0; i < 8; i++)
            vt[3+i] = '{1'b0, 8'(1 << (7 - i)), 1'b0, 16'h0020, (i == 7), 1'b0, 16'h0020};
        vt[11] = '{1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vt[12] = '{1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};

        for (int i = 0; i < 13; i++) begin
            cycle(vt[i].rst, vt[i].wr, vt[i].rd, row_inc(vt[i].base));
            chk($sformatf("vec%0d o_valid", i), 32'(o_valid), 32'(vt[i].exp_valid));
            chk($sformatf("vec%0d o_full", i), 32'(o_full), 32'(vt[i].exp_full));
            chk($sformatf("vec%0d o_ready", i), 32'(o_ready), 32'(!vt[i].exp_full));
            chk($sformatf("vec%0d o_err", i), 32'(o_err), 32'h0);
            if (vt[i].exp_valid) chk_row($sformatf("vec%0d out", i), row_inc(vt[i].exp_head));
        end

        // Fill to depth, overflow write, drain in order.
        cycle(1'b1, '0, 1'b0, '0);
        for (int r = 1; r <= DEPTH; r++) cycle(1'b0, '1, 1'b0, row_same(PB'(r)));
        chk("fill o_full", 32'(o_full), 32'h1);
        chk("fill o_ready", 32'(o_ready), 32'h0);
        chk("fill o_err", 32'(o_err), 32'h0);
        chk("fill o_valid", 32'(o_valid), 32'h1);
        cycle(1'b0, '1, 1'b0, row_same(16'hBEEF));
        chk("ovf o_err", 32'(o_err), 32'(ERR_EN));
        chk("ovf o_full", 32'(o_full), 32'h1);
        for (int r = 1; r <= DEPTH; r++) begin
            chk_row($sformatf("drain row %0d", r), row_same(PB'(r)));
            cycle(1'b0, '0, 1'b1, '0);
            chk("drain o_err held", 32'(o_err), 32'(ERR_EN));
        end
        chk("drain o_valid", 32'(o_valid), 32'h0);
        chk("drain o_full", 32'(o_full), 32'h0);
        cycle(1'b1, '0, 1'b0, '0);
        chk("post-reset o_err", 32'(o_err), 32'h0);

        // Streaming write+read every cycle across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            d = row_rand();
            cycle(1'b0, '1, 1'b1, d);
            chk("stream o_full", 32'(o_full), 32'h0);
            chk("stream o_valid", 32'(o_valid), 32'h1);
            chk_row($sformatf("stream row %0d", i), d);
        end

        // Reset mid-stream with data queued and a read pending.
        cycle(1'b1, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '1, 1'b0, row_rand());
        cycle(1'b1, '1, 1'b1, row_rand());
        chk("midreset o_valid", 32'(o_valid), 32'h0);
        chk("midreset o_ready", 32'(o_ready), 32'h1);
        chk("midreset o_full", 32'(o_full), 32'h0);
        d = row_rand();
        cycle(1'b0, '1, 1'b0, d);
        chk("fresh o_valid", 32'(o_valid), 32'h1);
        chk_row("fresh out", d);
        cycle(1'b0, '0, 1'b1, '0);
        chk("fresh popped o_valid", 32'(o_valid), 32'h0);

        // Random traffic in phases that alternately fill and drain the lanes.
        cycle(1'b1, '0, 1'b0, '0);
        check_model("rnd start");
        for (int i = 0; i < 3000; i++) begin
            case ((i / 200) % 3)
                0:       begin w = COL'($urandom | $urandom); rdp = 5;  end
                1:       begin w = COL'($urandom & $urandom); rdp = 90; end
                default: begin w = COL'($urandom);            rdp = 50; end
            endcase
            cycle(($urandom_range(0, 599) == 0), w, ($urandom_range(0, 99) < rdp), row_rand());
            check_model($sformatf("rnd %0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
